// File: rtl/cache_assoc_ctrl.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU replacement and burst miss handling.
// Optional hit/miss statistics counters are built when CACHE_ASSOC_STAT_EN is defined.
module cache_assoc_ctrl #(
  parameter int WAYS         = 4,
  parameter int OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH  = 5,
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [3:0]            cpu_byte_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int LINE_W    = INDEX_WIDTH + OFFSET_WIDTH;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, REFILL} state_t;
  state_t state_reg, state_next;

  logic                    we_reg;
  logic [3:0]              be_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    retry_reg;
  logic [WAY_W-1:0]        victim_reg;
  logic [OFFSET_WIDTH-1:0] beat_reg;

  logic [TAG_WIDTH-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_mem [WAYS][1<<LINE_W];
  logic [WAYS-1:0]       valid_reg [SETS];
  logic [WAYS-1:0]       dirty_reg [SETS];
  logic [WAY_W-1:0]      age_reg   [SETS][WAYS];

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_set;
  logic [OFFSET_WIDTH-1:0] req_word;
  assign {req_tag, req_set, req_word} = addr_reg;

  logic [WAYS-1:0]       hit_vec;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      victim;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [TAG_WIDTH-1:0]  vic_tag;
  logic [DATA_WIDTH-1:0] vic_word;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign hit_vec[gi] = valid_reg[req_set][gi] && (tag_mem[gi][req_set] == req_tag);
  end

  assign hit = |hit_vec;

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end

  // Oldest way is the fallback; the descending scan lets the lowest invalid way win.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_reg[req_set][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_reg[req_set][w]) victim = WAY_W'(w);
  end

  assign hit_word = data_mem[hit_way][{req_set, req_word}];
  assign vic_tag  = tag_mem[victim_reg][req_set];
  assign vic_word = data_mem[victim_reg][{req_set, beat_reg}];

  always_comb begin
    merged_word = hit_word;
    for (int i = 0; i < DATA_WIDTH / 8; i++)
      if (be_reg[i]) merged_word[8*i +: 8] = wdata_reg[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE: if (cpu_req) state_next = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          cpu_ready  = 1'b1;
          cpu_rdata  = hit_word;
          state_next = IDLE;
        end else if (valid_reg[req_set][victim] && dirty_reg[req_set][victim]) begin
          state_next = WB;
        end else begin
          state_next = REFILL;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vic_tag, req_set, beat_reg};
        mem_wdata = vic_word;
        if (mem_ack && beat_reg == LAST_BEAT) state_next = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_set, beat_reg};
        if (mem_ack && beat_reg == LAST_BEAT) state_next = LOOKUP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_reg     <= 1'b0;
      be_reg     <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      retry_reg  <= 1'b0;
      victim_reg <= '0;
      beat_reg   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_reg[s][w] <= WAY_W'(w);
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu_req) begin
            we_reg    <= cpu_we;
            be_reg    <= cpu_byte_en;
            addr_reg  <= cpu_addr;
            wdata_reg <= cpu_wdata;
            retry_reg <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (we_reg) dirty_reg[req_set][hit_way] <= 1'b1;
            // True LRU: the touched way becomes youngest, everything younger than it ages by one.
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_W'(w) == hit_way)
                age_reg[req_set][w] <= '0;
              else if (age_reg[req_set][w] < age_reg[req_set][hit_way])
                age_reg[req_set][w] <= age_reg[req_set][w] + 1'b1;
            end
          end else begin
            victim_reg <= victim;
            beat_reg   <= '0;
          end
        end
        WB: begin
          if (mem_ack) begin
            beat_reg <= beat_reg + 1'b1;
            if (beat_reg == LAST_BEAT) dirty_reg[req_set][victim_reg] <= 1'b0;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            beat_reg <= beat_reg + 1'b1;
            if (beat_reg == LAST_BEAT) begin
              valid_reg[req_set][victim_reg] <= 1'b1;
              dirty_reg[req_set][victim_reg] <= 1'b0;
              retry_reg                      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (state_reg == LOOKUP && hit && we_reg)
      data_mem[hit_way][{req_set, req_word}] <= merged_word;
    if (state_reg == REFILL && mem_ack) begin
      data_mem[victim_reg][{req_set, beat_reg}] <= mem_rdata;
      if (beat_reg == LAST_BEAT) tag_mem[victim_reg][req_set] <= req_tag;
    end
  end

`ifdef CACHE_ASSOC_STAT_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;

  // The post-refill retry lookup is part of the miss, so it is not counted again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (state_reg == LOOKUP) begin
      if (!hit)            miss_cnt_reg <= miss_cnt_reg + 32'd1;
      else if (!retry_reg) hit_cnt_reg  <= hit_cnt_reg + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: doc/cache_assoc_ctrl.md
Name: cache_assoc_ctrl

Overview:
N-way set-associative, write-back, write-allocate data cache with its own miss controller.
- Sits between the CPU load/store stage and the word-wide memory bus.
- Generalises the single direct-mapped way to WAYS ways with true-LRU replacement.
- Handles dirty-victim write-back and block refill with a per-word acknowledge handshake.

Parameters:
- WAYS, 4: associativity; power of two, 1..8.
- OFFSET_WIDTH, 3: log2 of words per block; BLOCK_SIZE = 1<<OFFSET_WIDTH.
- INDEX_WIDTH, 5: log2 of the number of sets.
- ADDR_WIDTH, 30: word address width.
- DATA_WIDTH, 32: word width.
- TAG_WIDTH, derived: ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH; never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_byte_en  in  4  store byte enables; bit i covers bits 8i+7..8i.
- cpu_addr  in  ADDR_WIDTH  word address, split as {tag, index, word_sel}.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data; valid only while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory word request.
- mem_we  out  1  1 = write-back word, 0 = refill read.
- mem_addr  out  ADDR_WIDTH  word address of the current burst beat.
- mem_wdata  out  DATA_WIDTH  write-back word.
- mem_rdata  in  DATA_WIDTH  refill word; valid with mem_ack.
- mem_ack  in  1  beat accepted/returned; one beat per acked cycle.
- hit_cnt  out  32  statistics, see Optional Feature.
- miss_cnt  out  32  statistics, see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all valid and dirty bits clear.
  - LRU age of way w set to w in every set.
  - cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata all 0.
  - Tag and data arrays are not reset.
- States: IDLE, LOOKUP, WB, REFILL.
- IDLE:
  - cpu_req=1 latches we, byte_en, addr, wdata; moves to LOOKUP.
  - CPU inputs are ignored after the latch until cpu_ready.
- LOOKUP: compare the latched tag against all valid ways of the set.
  - Hit:
    - cpu_ready=1 this cycle. Load: cpu_rdata = selected word. Store: write enabled bytes and set dirty at the edge.
    - LRU update: hit way age -> 0; ways with age below the old age increment by 1.
    - Next state IDLE. Hit latency = 1 cycle after acceptance.
  - Miss: choose the victim.
    - Victim is the lowest-index invalid way; otherwise the way with age WAYS-1.
    - Victim valid and dirty: go to WB. Otherwise go to REFILL.
- WB:
  - mem_req=1, mem_we=1.
  - mem_addr = {victim tag, index, beat}; mem_wdata = victim word[beat]; beat starts at 0.
  - Each mem_ack advances beat; mem_addr and mem_wdata hold until acked.
  - After the ack of beat BLOCK_SIZE-1: clear the victim's dirty bit, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {latched tag, index, beat}.
  - On each mem_ack, mem_rdata is written to victim word[beat].
  - After the last ack: victim tag = latched tag, valid=1, dirty=0; return to LOOKUP.
  - The retry LOOKUP always hits and completes the access as above, including store merge and LRU update.
  - Clean miss latency: 1 + BLOCK_SIZE acked beats + 1 cycle.
- mem_req drops in the cycle after the final ack; there are no idle gaps between beats other than waiting for ack.
- mem_ack outside WB/REFILL is ignored. Stalled beats (mem_ack=0) hold all outputs stable indefinitely.
- cpu_req dropping mid-miss does not abort the access; cpu_ready still pulses.
- WAYS=1 degenerates to direct-mapped; the LRU logic is constant.
- Reset mid-burst abandons the burst; memory contents are the bus owner's concern.

Optional Feature:
- Macro CACHE_ASSOC_STAT_EN.
- Defined:
  - hit_cnt increments on every LOOKUP that hits on first try.
  - miss_cnt increments on every LOOKUP that misses.
  - The retry LOOKUP after a refill counts as neither.
  - Both counters wrap at 2^32 and reset to 0.
- Not defined: hit_cnt and miss_cnt are constant 0 and no counter flops exist.

Test Plan (defaults, WAYS=4; mem model returns data = address; ack every cycle unless noted):
1. Cold load:
   - Stimulus: load addr 0x00000105 after reset.
   - Response: refill beats with mem_addr 0x100..0x107 and mem_we=0; cpu_ready with cpu_rdata=0x00000105, 10 cycles after acceptance; miss_cnt=1.
2. Store hit:
   - Stimulus: store 0xDEADBEEF, byte_en=4'b0011, to 0x105; then load 0x105.
   - Response: both ready 1 cycle after acceptance; load returns 0x0000BEEF; hit_cnt=2.
3. LRU eviction:
   - Stimulus: load blocks with tags 0..4 in set 0, each 1<<8 words apart; then touch tag 0 again.
   - Response: tag 4 evicts tag 0 (oldest); the retouch of tag 0 misses and evicts tag 1.
4. Dirty write-back:
   - Stimulus: store to 0x000, then fill set 0 with 4 other tags.
   - Response: WB burst mem_we=1, mem_addr 0x000..0x007 with the stored word at beat 0, followed by the refill burst.
5. Stalled memory:
   - Stimulus: mem_ack asserted only every 3rd cycle during refill.
   - Response: mem_addr holds per beat; correct data is returned; latency 1+24+1 cycles.
6. Reset mid-refill:
   - Stimulus: assert rst at beat 3.
   - Response: mem_req=0 and cpu_ready=0 immediately; subsequent load of the same address misses.
